corner_requester: RTL and testbench
===================================

Name: corner_requester

Overview:
- Initiator for the corner detector's start/done handshake. On a frame request it pulses `det_start`, waits for `det_done` with a timeout, and captures the 80-bit corner bus.
- It then sanity-checks corner ordering and streams the four (x,y) corners one per valid/ready handshake to the downstream rectilinearization transform.
- It is the single owner of the detector's `start` input.

Parameters:
- `COORD_W`, 10, width of one coordinate; the corner bus is 8*COORD_W.
- `TIMEOUT`, 1024, maximum cycles spent in WAIT before declaring a timeout (≥2).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `frame_go` in 1: single-cycle request for a new corner set.
- `det_start` out 1: start pulse to the corner detector.
- `det_done` in 1: single-cycle completion pulse from the detector.
- `det_corners` in 8*COORD_W: packed corners, MSB first, in the order x0,y0,x1,y1,x2,y2,x3,y3. Corners are TL, TR, BL, BR.
- `busy` out 1: high in any state other than IDLE.
- `corner_valid` out 1: streamed corner is valid.
- `corner_ready` in 1: downstream accepts the corner.
- `corner_idx` out 2: index 0..3 of the corner currently presented.
- `corner_x` out COORD_W: x coordinate of the presented corner.
- `corner_y` out COORD_W: y coordinate of the presented corner.
- `corner_last` out 1: high with `corner_valid` when `corner_idx` is 3.
- `err_timeout` out 1: one-cycle pulse on timeout.
- `err_order` out 1: one-cycle pulse on an ordering failure.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state IDLE, capture register 0, timeout counter 0.
- Reset asserted mid-operation aborts immediately. No stream or error pulse is resumed after reset.
- FSM states:
  - IDLE: on `frame_go`, go to REQ.
  - REQ: `det_start`=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: counter increments each cycle.
    - On `det_done`: capture `det_corners` on the same edge, go to CHECK.
    - Else, when counter = TIMEOUT-1: pulse `err_timeout`, go to IDLE.
    - `det_done` on the final timeout cycle wins; no error is raised.
  - CHECK, one cycle, on captured values:
    - Require x0<x1, x2<x3, y0<y2, y1<y3 (unsigned, strict).
    - On failure: pulse `err_order`, go to IDLE.
    - On pass: idx=0, go to STREAM.
  - STREAM: `corner_valid`=1; `corner_x`/`corner_y` come from the capture register slot `corner_idx`.
    - On `corner_valid`&&`corner_ready`: idx increments.
    - After the handshake on idx 3: drop `corner_valid` on the next cycle and go to IDLE.
    - Data is held stable while `corner_valid`&&!`corner_ready`. Backpressure is unbounded; no timeout applies in STREAM.
- Latency:
  - `frame_go` sampled at edge N → `det_start` high in cycle N+1.
  - `det_done` sampled at edge M → first `corner_valid` high in cycle M+2.
- Ignored inputs:
  - `frame_go` outside IDLE is dropped, not queued.
  - `det_done` outside WAIT is ignored, and the capture register is unchanged.
- `corner_x`, `corner_y`, and `corner_idx` hold their last values outside STREAM. Downstream qualifies them with `corner_valid` only.
- `err_timeout` and `err_order` are never high simultaneously.

Decomposition:
- Shared package `rect_pkg`:
  - COORD_W.
  - Corner index constants CORNER_TL=0, CORNER_TR=1, CORNER_BL=2, CORNER_BR=3.
  - Bus slice offsets for x/y of each corner.
  - FSM state encoding.
- One natural sub-module, `corner_order_check`: combinational ordering comparator on the 80-bit captured bus, output `ok`. It is reused later by the transform for assertion checks.

Test Plan:
- Nominal: detector model returns done 16 cycles after start with (192,144),(832,144),(192,880),(832,880); `corner_ready` tied 1. Required response:
  - `det_start` is a single cycle.
  - Four handshakes give idx 0..3, x=192,832,192,832 and y=144,144,880,880.
  - `corner_last` is high only at idx 3.
  - `busy` falls after the fourth handshake.
- Backpressure: `corner_ready` low for 5 cycles at idx 1 → `corner_x`=832 and `corner_y`=144 stay stable, idx stays 1, and no corner is skipped or duplicated.
- Timeout: TIMEOUT=32, detector never responds → `err_timeout` pulses exactly once, 32 cycles after the WAIT entry. The FSM returns to IDLE with no `corner_valid`.
- Done on the boundary: done arrives on the last WAIT cycle → no `err_timeout`, and the stream proceeds.
- Order error: detector returns x1=100 (< x0=192) → `err_order` pulses once, with no `corner_valid`.
- Reset and ignored inputs:
  - `frame_go` during STREAM is ignored, and a second `det_done` in STREAM leaves the data unchanged.
  - `rst_n` low mid-STREAM zeroes all outputs asynchronously.
  - After release, a fresh `frame_go` runs a complete transaction.

Source files
------------

// File: rtl/rect_pkg.sv
// Shared definitions for the corner requester and the rectilinearization path:
// corner indices, corner-bus slice offsets and the requester state encoding.
package rect_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned NUM_CORNERS = 4;

  localparam logic [1:0] CORNER_TL = 2'd0;
  localparam logic [1:0] CORNER_TR = 2'd1;
  localparam logic [1:0] CORNER_BL = 2'd2;
  localparam logic [1:0] CORNER_BR = 2'd3;

  // Bus is packed MSB first as x0,y0,x1,y1,x2,y2,x3,y3.
  function automatic int unsigned corner_x_lsb(input logic [1:0] idx, input int unsigned w);
    return (32'd7 - 32'd2 * 32'(idx)) * w;
  endfunction

  function automatic int unsigned corner_y_lsb(input logic [1:0] idx, input int unsigned w);
    return (32'd6 - 32'd2 * 32'(idx)) * w;
  endfunction

  localparam int unsigned X0_LSB = 7 * COORD_W;
  localparam int unsigned Y0_LSB = 6 * COORD_W;
  localparam int unsigned X1_LSB = 5 * COORD_W;
  localparam int unsigned Y1_LSB = 4 * COORD_W;
  localparam int unsigned X2_LSB = 3 * COORD_W;
  localparam int unsigned Y2_LSB = 2 * COORD_W;
  localparam int unsigned X3_LSB = 1 * COORD_W;
  localparam int unsigned Y3_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_STREAM = 3'd4
  } req_state_e;

endpackage

// File: rtl/corner_order_check.sv
// Combinational sanity check of corner geometry: TL left of TR, BL left of BR,
// TL above BL and TR above BR (unsigned, strict).
module corner_order_check
  import rect_pkg::*;
#(
  parameter int unsigned COORD_W = rect_pkg::COORD_W
) (
  input  logic [8*COORD_W-1:0] corners,
  output logic                 ok
);

  logic [COORD_W-1:0] x_tl, x_tr, x_bl, x_br;
  logic [COORD_W-1:0] y_tl, y_tr, y_bl, y_br;

  assign x_tl = corners[corner_x_lsb(CORNER_TL, COORD_W) +: COORD_W];
  assign x_tr = corners[corner_x_lsb(CORNER_TR, COORD_W) +: COORD_W];
  assign x_bl = corners[corner_x_lsb(CORNER_BL, COORD_W) +: COORD_W];
  assign x_br = corners[corner_x_lsb(CORNER_BR, COORD_W) +: COORD_W];
  assign y_tl = corners[corner_y_lsb(CORNER_TL, COORD_W) +: COORD_W];
  assign y_tr = corners[corner_y_lsb(CORNER_TR, COORD_W) +: COORD_W];
  assign y_bl = corners[corner_y_lsb(CORNER_BL, COORD_W) +: COORD_W];
  assign y_br = corners[corner_y_lsb(CORNER_BR, COORD_W) +: COORD_W];

  assign ok = (x_tl < x_tr) && (x_bl < x_br) && (y_tl < y_bl) && (y_tr < y_br);

endmodule

// File: rtl/corner_requester.sv
// Drives the corner detector start/done handshake with a timeout, checks the
// captured corner ordering and streams the four corners over valid/ready.
module corner_requester
  import rect_pkg::*;
#(
  parameter int unsigned COORD_W = rect_pkg::COORD_W,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_go,
  output logic                 det_start,
  input  logic                 det_done,
  input  logic [8*COORD_W-1:0] det_corners,
  output logic                 busy,
  output logic                 corner_valid,
  input  logic                 corner_ready,
  output logic [1:0]           corner_idx,
  output logic [COORD_W-1:0]   corner_x,
  output logic [COORD_W-1:0]   corner_y,
  output logic                 corner_last,
  output logic                 err_timeout,
  output logic                 err_order
);

  localparam int unsigned BUS_W = 8 * COORD_W;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  req_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUS_W-1:0]   cap_q, cap_d;
  logic               det_start_q, det_start_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [1:0]         idx_q, idx_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               last_q, last_d;
  logic               err_to_q, err_to_d;
  logic               err_or_q, err_or_d;

  logic               order_ok;
  logic [1:0]         next_idx;
  logic [COORD_W-1:0] slot_x [NUM_CORNERS];
  logic [COORD_W-1:0] slot_y [NUM_CORNERS];

  corner_order_check #(
    .COORD_W (COORD_W)
  ) u_order_check (
    .corners (cap_q),
    .ok      (order_ok)
  );

  for (genvar g = 0; g < NUM_CORNERS; g++) begin : g_slot
    assign slot_x[g] = cap_q[corner_x_lsb(2'(g), COORD_W) +: COORD_W];
    assign slot_y[g] = cap_q[corner_y_lsb(2'(g), COORD_W) +: COORD_W];
  end

  assign next_idx = idx_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    det_start_d = 1'b0;
    valid_d     = 1'b0;
    idx_d       = idx_q;
    x_d         = x_q;
    y_d         = y_q;
    last_d      = 1'b0;
    err_to_d    = 1'b0;
    err_or_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_go) begin
          state_d     = ST_REQ;
          det_start_d = 1'b1;
        end
      end
      ST_REQ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done on the final count takes priority over the timeout.
        if (det_done) begin
          cap_d   = det_corners;
          state_d = ST_CHECK;
        end else if (cnt_q == CNT_LAST) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (!order_ok) begin
          err_or_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_STREAM;
          valid_d = 1'b1;
          idx_d   = CORNER_TL;
          x_d     = slot_x[CORNER_TL];
          y_d     = slot_y[CORNER_TL];
        end
      end
      ST_STREAM: begin
        valid_d = 1'b1;
        last_d  = last_q;
        if (corner_ready) begin
          if (idx_q == CORNER_BR) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d  = next_idx;
            x_d    = slot_x[next_idx];
            y_d    = slot_y[next_idx];
            last_d = (next_idx == CORNER_BR);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cap_q       <= '0;
      det_start_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      last_q      <= 1'b0;
      err_to_q    <= 1'b0;
      err_or_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      det_start_q <= det_start_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      last_q      <= last_d;
      err_to_q    <= err_to_d;
      err_or_q    <= err_or_d;
    end
  end

  assign det_start    = det_start_q;
  assign busy         = busy_q;
  assign corner_valid = valid_q;
  assign corner_idx   = idx_q;
  assign corner_x     = x_q;
  assign corner_y     = y_q;
  assign corner_last  = last_q;
  assign err_timeout  = err_to_q;
  assign err_order    = err_or_q;

endmodule

// File: tb/tb_corner_requester.sv
// Scoreboard bench for corner_requester: a scripted detector feeds corner sets,
// expected corners are queued when done is driven and popped on each handshake.
module tb_corner_requester;

  localparam int CW = 10;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_go;
  logic          det_start;
  logic          det_done;
  logic [8*CW-1:0] det_corners;
  logic          busy;
  logic          corner_valid;
  logic          corner_ready;
  logic [1:0]    corner_idx;
  logic [CW-1:0] corner_x;
  logic [CW-1:0] corner_y;
  logic          corner_last;
  logic          err_timeout;
  logic          err_order;

  typedef struct packed {
    logic [1:0]    idx;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int to_cnt = 0;
  int or_cnt = 0;
  int valid_cnt = 0;
  int stall_cnt = 0;
  int bp_left = 0;

  corner_requester #(
    .COORD_W (CW),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_go     (frame_go),
    .det_start    (det_start),
    .det_done     (det_done),
    .det_corners  (det_corners),
    .busy         (busy),
    .corner_valid (corner_valid),
    .corner_ready (corner_ready),
    .corner_idx   (corner_idx),
    .corner_x     (corner_x),
    .corner_y     (corner_y),
    .corner_last  (corner_last),
    .err_timeout  (err_timeout),
    .err_order    (err_order)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [8*CW-1:0] mk_bus(input int x0, input int y0, input int x1, input int y1,
                                             input int x2, input int y2, input int x3, input int y3);
    return {CW'(x0), CW'(y0), CW'(x1), CW'(y1), CW'(x2), CW'(y2), CW'(x3), CW'(y3)};
  endfunction

  function automatic logic [CW-1:0] bus_x(input logic [8*CW-1:0] b, input int i);
    return b[(7 - 2*i)*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] bus_y(input logic [8*CW-1:0] b, input int i);
    return b[(6 - 2*i)*CW +: CW];
  endfunction

  function automatic bit order_ok(input logic [8*CW-1:0] b);
    return (bus_x(b, 0) < bus_x(b, 1)) && (bus_x(b, 2) < bus_x(b, 3)) &&
           (bus_y(b, 0) < bus_y(b, 2)) && (bus_y(b, 1) < bus_y(b, 3));
  endfunction

  task automatic push_exp(input logic [8*CW-1:0] b);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.idx = 2'(i);
      e.x   = bus_x(b, i);
      e.y   = bus_y(b, i);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_start"}, det_start, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_valid"}, corner_valid, 0);
    chk({pfx, "_idx"}, corner_idx, 0);
    chk({pfx, "_x"}, corner_x, 0);
    chk({pfx, "_y"}, corner_y, 0);
    chk({pfx, "_last"}, corner_last, 0);
    chk({pfx, "_errto"}, err_timeout, 0);
    chk({pfx, "_error"}, err_order, 0);
  endtask

  // k: cycles from the det_start edge to the edge that samples det_done.
  task automatic run_frame(input int k, input logic [8*CW-1:0] b, input bit respond);
    bit ok;
    int t;
    ok = order_ok(b);
    tick();
    frame_go = 1'b1;
    tick();
    frame_go = 1'b0;
    chk("start_hi", det_start, 1);
    tick();
    chk("start_pulse", det_start, 0);
    if (respond) begin
      repeat (k - 1) tick();
      det_done = 1'b1;
      det_corners = b;
      if (ok) push_exp(b);
      tick();
      det_done = 1'b0;
      chk("check_cycle_valid", corner_valid, 0);
      tick();
      chk("first_valid", corner_valid, ok);
      chk("err_order_hi", err_order, !ok);
      if (!ok) begin
        tick();
        chk("err_order_pulse", err_order, 0);
        chk("order_busy", busy, 0);
      end
    end else begin
      t = 1;
      while (!err_timeout && t < 60) begin
        tick();
        t++;
      end
      chk("to_latency", t, 33);
      tick();
      chk("to_pulse", err_timeout, 0);
      chk("to_busy", busy, 0);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_idx1(input string tag);
    int n = 0;
    while (!(corner_valid && corner_idx == 2'd1) && n < 50) begin
      tick();
      n++;
    end
    chk(tag, corner_valid && corner_idx == 2'd1, 1);
  endtask

  // Downstream ready: stalls only at idx 1 while bp_left is nonzero.
  initial begin
    corner_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bp_left > 0 && corner_valid && corner_idx == 2'd1) begin
        corner_ready = 1'b0;
        bp_left--;
      end else begin
        corner_ready = 1'b1;
      end
    end
  end

  // Output monitor and scoreboard consumer.
  initial begin
    bit hold_pend = 0;
    bit last_pend = 0;
    logic [1:0] h_idx;
    logic [CW-1:0] h_x, h_y;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 0;
        last_pend = 0;
      end else begin
        if (last_pend) begin
          chk("busy_fall", busy, 0);
          chk("valid_drop", corner_valid, 0);
          last_pend = 0;
        end
        if (hold_pend) begin
          chk("hold_valid", corner_valid, 1);
          chk("hold_idx", corner_idx, h_idx);
          chk("hold_x", corner_x, h_x);
          chk("hold_y", corner_y, h_y);
          hold_pend = 0;
        end
        if (det_start) start_cnt++;
        if (err_timeout) to_cnt++;
        if (err_order) or_cnt++;
        if (err_timeout || err_order) chk("err_excl", err_timeout & err_order, 0);
        if (corner_valid) begin
          valid_cnt++;
          chk("last_flag", corner_last, corner_idx == 2'd3);
        end else if (corner_last) begin
          chk("last_novalid", corner_last, 0);
        end
        if (corner_valid && corner_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_extra", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_idx", corner_idx, e.idx);
            chk("sb_x", corner_x, e.x);
            chk("sb_y", corner_y, e.y);
          end
          if (corner_idx == 2'd3) last_pend = 1;
        end else if (corner_valid) begin
          stall_cnt++;
          hold_pend = 1;
          h_idx = corner_idx;
          h_x = corner_x;
          h_y = corner_y;
        end
      end
    end
  end

  initial begin
    logic [8*CW-1:0] nom, alt, bad_bus, bogus;
    int start_before, to_before, or_before, v_before;
    nom     = mk_bus(192, 144, 832, 144, 192, 880, 832, 880);
    alt     = mk_bus(10, 20, 600, 30, 15, 700, 620, 710);
    bad_bus = mk_bus(192, 144, 100, 144, 192, 880, 832, 880);
    bogus   = mk_bus(1, 2, 3, 4, 5, 6, 7, 8);

    rst_n = 1'b0;
    frame_go = 1'b0;
    det_done = 1'b0;
    det_corners = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    run_frame(15, nom, 1'b1);
    wait_idle("nom_idle");
    chk("nom_sb_empty", exp_q.size(), 0);

    stall_cnt = 0;
    bp_left = 5;
    start_before = start_cnt;
    run_frame(15, nom, 1'b1);
    wait_idx1("bp_reach");
    chk("bp_x", corner_x, 832);
    chk("bp_y", corner_y, 144);
    frame_go = 1'b1;
    det_done = 1'b1;
    det_corners = bogus;
    tick();
    frame_go = 1'b0;
    det_done = 1'b0;
    wait_idle("bp_idle");
    chk("bp_stalls", stall_cnt, 5);
    chk("bp_sb_empty", exp_q.size(), 0);
    repeat (4) tick();
    chk("go_dropped_busy", busy, 0);
    chk("go_dropped_start", start_cnt - start_before, 1);

    to_before = to_cnt;
    v_before = valid_cnt;
    run_frame(0, nom, 1'b0);
    chk("to_once", to_cnt - to_before, 1);
    chk("to_novalid", valid_cnt - v_before, 0);

    to_before = to_cnt;
    run_frame(32, alt, 1'b1);
    wait_idle("edge_idle");
    chk("edge_no_timeout", to_cnt - to_before, 0);
    chk("edge_sb_empty", exp_q.size(), 0);

    or_before = or_cnt;
    v_before = valid_cnt;
    run_frame(15, bad_bus, 1'b1);
    repeat (3) tick();
    chk("order_once", or_cnt - or_before, 1);
    chk("order_novalid", valid_cnt - v_before, 0);

    bp_left = 1000;
    run_frame(15, nom, 1'b1);
    wait_idx1("rst_reach");
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    bp_left = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    run_frame(15, alt, 1'b1);
    wait_idle("post_idle");
    chk("post_sb_empty", exp_q.size(), 0);
    chk("start_total", start_cnt, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
